// File: rtl/stopwatch_display_scan_if.sv
// stopwatch_display_scan_if: digit bus from the stopwatch counter plus the multiplexed display lines
interface stopwatch_display_scan_if;
    logic       mode;
    logic       lz_en;
    logic [3:0] timer10ms;
    logic [3:0] timer100ms;
    logic [3:0] timer1sec;
    logic [3:0] timer10sec;
    logic [3:0] timer1min;
    logic [3:0] timer10min;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_start;
    modport master (
        output mode, lz_en, timer10ms, timer100ms, timer1sec, timer10sec, timer1min, timer10min,
        input  an, seg, dp, frame_start
    );
    modport slave (
        input  mode, lz_en, timer10ms, timer100ms, timer1sec, timer10sec, timer1min, timer10min,
        output an, seg, dp, frame_start
    );
endinterface

// File: rtl/stopwatch_display_scan.sv
// stopwatch_display_scan: six-digit common-anode scanner with per-frame snapshot,
// anti-ghost blanking and optional minute leading-zero suppression
module stopwatch_display_scan #(
    parameter int TICKS_PER_DIGIT = 4,
    parameter int BLANK_TICKS     = 1
) (
    input logic                    clk,
    input logic                    reset,
    stopwatch_display_scan_if.slave bus
);
    localparam int TW = $clog2(TICKS_PER_DIGIT);
    logic [TW-1:0] tick;
    logic [2:0]    idx;
    logic [3:0]    snap [6];
    logic          last, blank, sup, dark, dp_n, fs_n;
    logic [5:0]    an_n;
    logic [6:0]    seg_n;
    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction
    always_comb begin
        last  = tick == TW'(TICKS_PER_DIGIT - 1);
        blank = int'(tick) < BLANK_TICKS;
        sup   = bus.lz_en && snap[5] == 4'd0 && (idx == 3'd5 || (idx == 3'd4 && snap[4] == 4'd0));
        dark  = !bus.mode || blank || sup;
        an_n  = dark ? 6'h3F : ~(6'd1 << idx);
        seg_n = dark ? 7'h7F : decode(snap[idx]);
        dp_n  = dark || !(idx == 3'd2 || idx == 3'd4);
        fs_n  = idx == 3'd0 && tick == '0;
    end
    // Snapshot on the last cycle of slot 5 so every frame shows one coherent sample
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick            <= '0;
            idx             <= '0;
            snap            <= '{default: 4'd0};
            bus.an          <= 6'h3F;
            bus.seg         <= 7'h7F;
            bus.dp          <= 1'b1;
            bus.frame_start <= 1'b0;
        end else begin
            tick <= last ? '0 : tick + 1'b1;
            if (last)
                idx <= idx == 3'd5 ? 3'd0 : idx + 3'd1;
            if (last && idx == 3'd5)
                snap <= '{bus.timer10ms, bus.timer100ms, bus.timer1sec,
                          bus.timer10sec, bus.timer1min, bus.timer10min};
            bus.an          <= an_n;
            bus.seg         <= seg_n;
            bus.dp          <= dp_n;
            bus.frame_start <= fs_n;
        end
    end
endmodule
